l2_cache_ctrl_burst: RTL

//  Parametrised L2 control FSM for an N-way, write-back cache. It drives a multi-beat

---
 rtl/l2_cache_ctrl_burst.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/l2_cache_ctrl_burst.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : l2_cache_ctrl_burst
// Purpose  : N-way write-back L2 control FSM with burst pmem writeback/fill,
//            LRU victim selection and internal replay after each fill.
// Options  : L2_CTRL_STATS_EN builds the saturating hit/miss/writeback counters.
// Revision : 1.0
// ---------------------------------------------------------------------------
module l2_cache_ctrl_burst #(
    parameter int WAYS        = 2,
    parameter int BURST_BEATS = 4,
    parameter int CNT_W       = 32,
    localparam int WAY_W      = $clog2(WAYS),
    localparam int BEAT_W     = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              hit_i,
    input  logic [WAY_W-1:0]  hit_way_i,
    input  logic [WAY_W-1:0]  lru_way_i,
    input  logic [WAYS-1:0]   way_dirty_i,
    input  logic              pmem_resp_i,
    output logic              cache_resp_o,
    output logic              read_data_o,
    output logic              load_data_o,
    output logic              load_tag_o,
    output logic              set_valid_o,
    output logic              set_dirty_o,
    output logic              clear_dirty_o,
    output logic              load_lru_o,
    output logic [WAY_W-1:0]  way_sel_o,
    output logic [BEAT_W-1:0] beat_idx_o,
    output logic              pmem_addr_sel_o,
    output logic              pmem_read_o,
    output logic              pmem_write_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  hit_count_o,
    output logic [CNT_W-1:0]  miss_count_o,
    output logic [CNT_W-1:0]  wb_count_o
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_HIT_DETECT = 2'd1,
        S_WRITEBACK  = 2'd2,
        S_FILL       = 2'd3
    } state_t;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_BEATS - 1);

    state_t            state_q, state_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              req;
    logic              last_beat;

    assign req        = mem_read_i | mem_write_i;
    assign last_beat  = (beat_q == LAST_BEAT);
    assign beat_idx_o = beat_q;
    assign busy_o     = (state_q != S_IDLE);

    always_comb begin
        state_d         = state_q;
        victim_d        = victim_q;
        beat_d          = beat_q;
        cache_resp_o    = 1'b0;
        read_data_o     = 1'b0;
        load_data_o     = 1'b0;
        load_tag_o      = 1'b0;
        set_valid_o     = 1'b0;
        set_dirty_o     = 1'b0;
        clear_dirty_o   = 1'b0;
        load_lru_o      = 1'b0;
        way_sel_o       = '0;
        pmem_addr_sel_o = 1'b0;
        pmem_read_o     = 1'b0;
        pmem_write_o    = 1'b0;
        // Strobes are forced low while reset is held, even if a request is pending.
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        read_data_o = 1'b1;
                        state_d     = S_HIT_DETECT;
                    end
                end
                S_HIT_DETECT: begin
                    if (!req) begin
                        state_d = S_IDLE;
                    end else if (hit_i) begin
                        cache_resp_o = 1'b1;
                        load_lru_o   = 1'b1;
                        way_sel_o    = hit_way_i;
                        if (mem_write_i) begin
                            load_data_o = 1'b1;
                            set_dirty_o = 1'b1;
                        end else begin
                            read_data_o = 1'b1;
                        end
                        state_d = S_IDLE;
                    end else begin
                        victim_d = lru_way_i;
                        beat_d   = '0;
                        state_d  = way_dirty_i[lru_way_i] ? S_WRITEBACK : S_FILL;
                    end
                end
                S_WRITEBACK: begin
                    pmem_write_o    = 1'b1;
                    pmem_addr_sel_o = 1'b1;
                    way_sel_o       = victim_q;
                    read_data_o     = 1'b1;
                    if (pmem_resp_i) begin
                        if (last_beat) begin
                            clear_dirty_o = 1'b1;
                            beat_d        = '0;
                            state_d       = S_FILL;
                        end else begin
                            beat_d = beat_q + BEAT_W'(1);
                        end
                    end
                end
                S_FILL: begin
                    pmem_read_o = 1'b1;
                    way_sel_o   = victim_q;
                    if (pmem_resp_i) begin
                        load_data_o = 1'b1;
                        if (last_beat) begin
                            load_tag_o  = 1'b1;
                            set_valid_o = 1'b1;
                            load_lru_o  = 1'b1;
                            beat_d      = '0;
                            state_d     = S_HIT_DETECT;
                        end else begin
                            beat_d = beat_q + BEAT_W'(1);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            victim_q <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            beat_q   <= beat_d;
        end
    end

`ifdef L2_CTRL_STATS_EN
    logic             replay_q, replay_d;
    logic             hit_evt, miss_evt, wb_evt;
    logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

    assign hit_evt  = (state_q == S_HIT_DETECT) && req && hit_i && !replay_q;
    assign miss_evt = (state_q == S_HIT_DETECT) && req && !hit_i && !replay_q;
    assign wb_evt   = (state_q == S_WRITEBACK) && pmem_resp_i && last_beat;

    // Replay marks the post-fill pass so it is not counted a second time.
    always_comb begin
        replay_d = replay_q;
        if (state_q == S_FILL && pmem_resp_i && last_beat) begin
            replay_d = 1'b1;
        end else if (state_q == S_HIT_DETECT && (!req || hit_i)) begin
            replay_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            replay_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            replay_q <= replay_d;
            if (hit_evt && hit_cnt_q != '1) begin
                hit_cnt_q <= hit_cnt_q + CNT_W'(1);
            end
            if (miss_evt && miss_cnt_q != '1) begin
                miss_cnt_q <= miss_cnt_q + CNT_W'(1);
            end
            if (wb_evt && wb_cnt_q != '1) begin
                wb_cnt_q <= wb_cnt_q + CNT_W'(1);
            end
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
    assign wb_count_o   = wb_cnt_q;
`else
    assign hit_count_o  = '0;
    assign miss_count_o = '0;
    assign wb_count_o   = '0;
`endif

endmodule
`default_nettype wire
